div_period_monitor: RTL and testbench

//  Receive-side checker for the fractional M/N clock divider: samples the divided clock
//  (sig_in) in the clk_in domain, measures every period and high time in clk_in cycles,

---
 rtl/div_period_monitor_if.sv | 31 +++
 rtl/div_period_monitor.sv | 164 ++++++++++++++++
 tb/tb_div_period_monitor.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/div_period_monitor_if.sv
// Signal bundle between the divided clock under test, its control and the period monitor.
// The master drives sig_in/clr and observes results; the monitor itself is the slave.
interface div_period_monitor_if #(
    parameter int CW = 8
);
    logic          sig_in;
    logic          clr;
    logic          period_vld;
    logic [CW-1:0] period_len;
    logic [CW-1:0] high_len;
    logic          frame_vld;
    logic [3:0]    n_short;
    logic [3:0]    n_long;
    logic [CW-1:0] frame_cyc;
    logic          period_err;
    logic          duty_err;
    logic          frame_err;
    logic          stuck;

    modport master (
        output sig_in, clr,
        input  period_vld, period_len, high_len, frame_vld, n_short, n_long,
               frame_cyc, period_err, duty_err, frame_err, stuck
    );

    modport slave (
        input  sig_in, clr,
        output period_vld, period_len, high_len, frame_vld, n_short, n_long,
               frame_cyc, period_err, duty_err, frame_err, stuck
    );
endinterface

// File: rtl/div_period_monitor.sv
// Measures period and high time of a divided clock in clk_in cycles, classifies each
// period as short/long and checks every FRAME_PER-period frame against M_N.
module div_period_monitor #(
    parameter int M_N       = 87,
    parameter int FRAME_PER = 10,
    parameter int DIV_E     = 8,
    parameter int DIV_O     = 9,
    parameter int TIMEOUT   = 32,
    parameter int CW        = 8
) (
    input  logic                clk_in,
    input  logic                rst,
    div_period_monitor_if.slave mon
);
    localparam int            IDX_W   = (FRAME_PER > 1) ? $clog2(FRAME_PER) : 1;
    localparam logic [CW-1:0] CNT_MAX = '1;

    typedef enum logic {IDLE, ARMED} state_t;
    state_t state, state_next;

    logic             sig_q;
    logic             rise;
    logic [CW-1:0]    per_cnt;
    logic [CW-1:0]    hi_cnt;
    logic [CW-1:0]    cyc_acc;
    logic [3:0]       short_acc;
    logic [3:0]       long_acc;
    logic [IDX_W-1:0] per_idx;

    logic             arm;
    logic             report;
    logic             timeout;
    logic             is_short;
    logic             is_long;
    logic             frame_end;
    logic [CW:0]      acc_sum;
    logic [CW-1:0]    acc_next;
    logic [3:0]       short_next;
    logic [3:0]       long_next;

    assign rise = mon.sig_in & ~sig_q;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // NOTE: every signal driven here gets a default first, so no latch can be inferred.
    always_comb begin
        state_next = state;
        arm        = 1'b0;
        report     = 1'b0;
        timeout    = 1'b0;
        if (mon.clr) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (rise) begin
                        arm        = 1'b1;
                        state_next = ARMED;
                    end
                end
                ARMED: begin
                    if (rise) begin
                        report = 1'b1;
                    end else if (per_cnt == CW'(TIMEOUT - 1)) begin
                        timeout    = 1'b1;
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Values of the period being closed, including its contribution to the running frame.
    always_comb begin
        is_short   = (per_cnt == CW'(DIV_E));
        is_long    = (per_cnt == CW'(DIV_O));
        acc_sum    = {1'b0, cyc_acc} + {1'b0, per_cnt};
        acc_next   = acc_sum[CW] ? CNT_MAX : acc_sum[CW-1:0];
        short_next = short_acc + {3'b000, is_short};
        long_next  = long_acc + {3'b000, is_long};
        frame_end  = (per_idx == IDX_W'(FRAME_PER - 1));
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            sig_q          <= 1'b0;
            per_cnt        <= '0;
            hi_cnt         <= '0;
            cyc_acc        <= '0;
            short_acc      <= '0;
            long_acc       <= '0;
            per_idx        <= '0;
            mon.period_vld <= 1'b0;
            mon.period_len <= '0;
            mon.high_len   <= '0;
            mon.frame_vld  <= 1'b0;
            mon.n_short    <= '0;
            mon.n_long     <= '0;
            mon.frame_cyc  <= '0;
            mon.period_err <= 1'b0;
            mon.duty_err   <= 1'b0;
            mon.frame_err  <= 1'b0;
            mon.stuck      <= 1'b0;
        end else begin
            sig_q          <= mon.sig_in;
            mon.period_vld <= 1'b0;
            mon.frame_vld  <= 1'b0;
            if (mon.clr) begin
                // Reported values (period_len, high_len, n_*, frame_cyc) are left holding.
                per_cnt        <= '0;
                hi_cnt         <= '0;
                cyc_acc        <= '0;
                short_acc      <= '0;
                long_acc       <= '0;
                per_idx        <= '0;
                mon.period_err <= 1'b0;
                mon.duty_err   <= 1'b0;
                mon.frame_err  <= 1'b0;
                mon.stuck      <= 1'b0;
            end else if (arm) begin
                per_cnt   <= CW'(1);
                hi_cnt    <= CW'(1);
                cyc_acc   <= '0;
                short_acc <= '0;
                long_acc  <= '0;
                per_idx   <= '0;
            end else if (report) begin
                mon.period_vld <= 1'b1;
                mon.period_len <= per_cnt;
                mon.high_len   <= hi_cnt;
                per_cnt        <= CW'(1);
                hi_cnt         <= CW'(1);
                if (!is_short && !is_long)     mon.period_err <= 1'b1;
                if (hi_cnt != (per_cnt >> 1)) mon.duty_err   <= 1'b1;
                if (frame_end) begin
                    mon.frame_vld <= 1'b1;
                    mon.n_short   <= short_next;
                    mon.n_long    <= long_next;
                    mon.frame_cyc <= acc_next;
                    if (acc_next != CW'(M_N)) mon.frame_err <= 1'b1;
                    per_idx   <= '0;
                    cyc_acc   <= '0;
                    short_acc <= '0;
                    long_acc  <= '0;
                end else begin
                    per_idx   <= per_idx + IDX_W'(1);
                    cyc_acc   <= acc_next;
                    short_acc <= short_next;
                    long_acc  <= long_next;
                end
            end else if (timeout) begin
                mon.stuck <= 1'b1;
            end else if (state == ARMED) begin
                if (per_cnt != CNT_MAX)                 per_cnt <= per_cnt + CW'(1);
                if (mon.sig_in && (hi_cnt != CNT_MAX)) hi_cnt  <= hi_cnt + CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_div_period_monitor.sv
// Directed bench for div_period_monitor: table of periods with hand-computed reports,
// plus sequences for timeout, clr coincident with a rise, and asynchronous reset.
module tb_div_period_monitor;
    typedef struct {
        int         len;
        int         hi;
        logic [7:0] plen;
        logic [7:0] hlen;
        logic       fvld;
        logic [3:0] ns;
        logic [3:0] nl;
        logic [7:0] fcyc;
        logic [3:0] flags;   // {period_err, duty_err, frame_err, stuck}
    } vec_t;

    typedef struct {
        logic [7:0] plen;
        logic [7:0] hlen;
        logic       fvld;
        logic [3:0] ns;
        logic [3:0] nl;
        logic [7:0] fcyc;
        logic [3:0] flags;
    } rep_t;

    logic clk_in = 1'b0;
    logic rst    = 1'b1;

    div_period_monitor_if #(.CW(8)) mon ();

    div_period_monitor dut (
        .clk_in (clk_in),
        .rst    (rst),
        .mon    (mon.slave)
    );

    always #5 clk_in = ~clk_in;

    vec_t tbl[$];
    rep_t obs_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic logic [3:0] flags_now();
        return {mon.period_err, mon.duty_err, mon.frame_err, mon.stuck};
    endfunction

    // Every pulse of either valid is captured for later comparison against the table.
    always @(negedge clk_in) begin
        if (!rst && (mon.period_vld || mon.frame_vld))
            obs_q.push_back('{mon.period_len, mon.high_len, mon.frame_vld,
                              mon.n_short, mon.n_long, mon.frame_cyc, flags_now()});
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got no summary, required completion");
        $fatal(1, "time limit");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic add(input int len, input int hi, input logic fvld, input logic [3:0] ns,
                       input logic [3:0] nl, input logic [7:0] fcyc, input logic [3:0] flags);
        vec_t v;
        v.len = len;  v.hi = hi;
        v.plen = 8'(len);  v.hlen = 8'(hi);
        v.fvld = fvld;  v.ns = ns;  v.nl = nl;  v.fcyc = fcyc;  v.flags = flags;
        tbl.push_back(v);
    endtask

    task automatic drive_period(input int len, input int hi);
        for (int i = 0; i < len; i++) begin
            @(negedge clk_in);
            mon.sig_in = (i < hi);
        end
    endtask

    // Drives tbl[first..last] back to back, closes the last one with a single-cycle rise,
    // then compares every captured report with the table.
    task automatic run_table(input int first, input int last);
        int n_exp;
        n_exp = last - first + 1;
        for (int i = first; i <= last; i++) drive_period(tbl[i].len, tbl[i].hi);
        @(negedge clk_in); mon.sig_in = 1'b1;
        @(negedge clk_in); mon.sig_in = 1'b0;
        @(negedge clk_in);
        check($sformatf("report count v%0d..v%0d", first, last), obs_q.size(), n_exp);
        for (int i = 0; i < n_exp && i < obs_q.size(); i++) begin
            check($sformatf("v%0d period_len", first + i), obs_q[i].plen,  tbl[first + i].plen);
            check($sformatf("v%0d high_len",   first + i), obs_q[i].hlen,  tbl[first + i].hlen);
            check($sformatf("v%0d frame_vld",  first + i), obs_q[i].fvld,  tbl[first + i].fvld);
            check($sformatf("v%0d n_short",    first + i), obs_q[i].ns,    tbl[first + i].ns);
            check($sformatf("v%0d n_long",     first + i), obs_q[i].nl,    tbl[first + i].nl);
            check($sformatf("v%0d frame_cyc",  first + i), obs_q[i].fcyc,  tbl[first + i].fcyc);
            check($sformatf("v%0d flags",      first + i), obs_q[i].flags, tbl[first + i].flags);
        end
        obs_q.delete();
    endtask

    initial begin
        mon.sig_in = 1'b0;
        mon.clr    = 1'b0;

        // v0..v9: 3x8 + 7x9 = 87; v10..v19: same frame again
        for (int i = 0; i < 9; i++) add((i < 3) ? 8 : 9, 4, 1'b0, 4'd0, 4'd0, 8'd0, 4'b0000);
        add(9, 4, 1'b1, 4'd3, 4'd7, 8'd87, 4'b0000);
        for (int i = 0; i < 9; i++) add((i < 3) ? 8 : 9, 4, 1'b0, 4'd3, 4'd7, 8'd87, 4'b0000);
        add(9, 4, 1'b1, 4'd3, 4'd7, 8'd87, 4'b0000);
        // v20..v29: constant div-by-8, frame of 80 -> frame_err
        for (int i = 0; i < 9; i++) add(8, 4, 1'b0, 4'd3, 4'd7, 8'd87, 4'b0000);
        add(8, 4, 1'b1, 4'd10, 4'd0, 8'd80, 4'b0010);
        // v30..v39: period 10 (period_err), 9 high 6 (duty_err, still long), 8x8 -> 83
        add(10, 5, 1'b0, 4'd10, 4'd0, 8'd80, 4'b1010);
        add(9, 6, 1'b0, 4'd10, 4'd0, 8'd80, 4'b1110);
        for (int i = 0; i < 7; i++) add(8, 4, 1'b0, 4'd10, 4'd0, 8'd80, 4'b1110);
        add(8, 4, 1'b1, 4'd8, 4'd1, 8'd83, 4'b1110);
        // v40..v42: restart after stuck, all flags sticky
        for (int i = 0; i < 3; i++) add(8, 4, 1'b0, 4'd8, 4'd1, 8'd83, 4'b1111);
        // v43..v52: fresh frame after clr, frame outputs held until frame end
        for (int i = 0; i < 9; i++) add((i < 3) ? 8 : 9, 4, 1'b0, 4'd8, 4'd1, 8'd83, 4'b0000);
        add(9, 4, 1'b1, 4'd3, 4'd7, 8'd87, 4'b0000);
        // v53..v62: fresh frame after reset
        for (int i = 0; i < 9; i++) add((i < 3) ? 8 : 9, 4, 1'b0, 4'd0, 4'd0, 8'd0, 4'b0000);
        add(9, 4, 1'b1, 4'd3, 4'd7, 8'd87, 4'b0000);

        // Reset state
        @(negedge clk_in);
        @(negedge clk_in);
        check("reset period_vld", mon.period_vld, 0);
        check("reset frame_vld",  mon.frame_vld,  0);
        check("reset period_len", mon.period_len, 0);
        check("reset frame_cyc",  mon.frame_cyc,  0);
        check("reset flags",      flags_now(),    0);
        rst = 1'b0;

        run_table(0, 39);

        // sig_in held low: closing rise was 3 negedges ago; stuck visible 31 cycles after it
        for (int k = 3; k <= 40; k++) begin
            @(negedge clk_in);
            if (k == 31) check("stuck before timeout", mon.stuck, 0);
            if (k == 32) check("stuck at timeout",     mon.stuck, 1);
        end
        check("no reports while stuck", obs_q.size(), 0);

        run_table(40, 42);

        // clr coincident with a rise while armed
        @(negedge clk_in); mon.sig_in = 1'b1; mon.clr = 1'b1;
        @(negedge clk_in); mon.clr = 1'b0;
        check("clr period_vld",      mon.period_vld, 0);
        check("clr flags",           flags_now(),    0);
        check("clr period_len hold", mon.period_len, 8);
        check("clr n_long hold",     mon.n_long,     1);
        mon.sig_in = 1'b1;
        for (int i = 2; i < 8; i++) begin
            @(negedge clk_in);
            mon.sig_in = (i < 4);
        end
        run_table(43, 52);

        // Asynchronous reset mid-frame, asserted away from any clock edge
        for (int i = 0; i < 3; i++) drive_period(8, 4);
        @(negedge clk_in); mon.sig_in = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("async rst period_len", mon.period_len, 0);
        check("async rst high_len",   mon.high_len,   0);
        check("async rst n_short",    mon.n_short,    0);
        check("async rst frame_cyc",  mon.frame_cyc,  0);
        check("async rst flags",      flags_now(),    0);
        @(negedge clk_in);
        @(negedge clk_in);
        obs_q.delete();
        rst = 1'b0;
        run_table(53, 62);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end
endmodule
